// File: rtl/serial_nibble_deserializer_if.sv
// Bundle of serial-side inputs and word-side outputs for serial_nibble_deserializer.
//   bit_valid, bit_in, frame_start : serial stream (source -> deserializer)
//   nibble_out, load_en            : word and load strobe for the downstream register
//   parity_err, busy               : status
// master = stream source / consumer, slave = deserializer.
interface serial_nibble_deserializer_if #(
  parameter int WIDTH = 4
);
  logic             bit_valid;
  logic             bit_in;
  logic             frame_start;
  logic [WIDTH-1:0] nibble_out;
  logic             load_en;
  logic             parity_err;
  logic             busy;

  modport master (
    output bit_valid, bit_in, frame_start,
    input  nibble_out, load_en, parity_err, busy
  );

  modport slave (
    input  bit_valid, bit_in, frame_start,
    output nibble_out, load_en, parity_err, busy
  );
endinterface

// File: rtl/serial_nibble_deserializer.sv
// Framed serial-to-parallel front end. Collects WIDTH data bits (plus an
// optional even-parity bit), presents each good word on nibble_out with a
// one-cycle load_en strobe, and drops bad frames with a one-cycle parity_err.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous, active-low
//   bus   : serial_nibble_deserializer_if.slave (stream in, word/status out)
// All outputs come from registers; busy decodes the state register only.
module serial_nibble_deserializer #(
  parameter int WIDTH     = 4,
  parameter int PARITY_EN = 1,
  parameter int MSB_FIRST = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  serial_nibble_deserializer_if.slave   bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, DATA, PAR} state_t;

  state_t           state, state_n;
  logic [CW-1:0]    bit_cnt, bit_cnt_n;
  logic [WIDTH-1:0] shreg, shreg_n;
  logic [WIDTH-1:0] nibble_q, nibble_n;
  logic             load_q, load_n;
  logic             perr_q, perr_n;
  int               idx;
  int               pos;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      shreg    <= '0;
      nibble_q <= '0;
      load_q   <= 1'b0;
      perr_q   <= 1'b0;
    end else begin
      state    <= state_n;
      bit_cnt  <= bit_cnt_n;
      shreg    <= shreg_n;
      nibble_q <= nibble_n;
      load_q   <= load_n;
      perr_q   <= perr_n;
    end
  end

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    nibble_n  = nibble_q;
    load_n    = 1'b0;
    perr_n    = 1'b0;
    // A frame_start bit is always data bit 0, whatever state we are in.
    idx       = bus.frame_start ? 0 : int'(bit_cnt);
    pos       = (MSB_FIRST != 0) ? (WIDTH - 1 - idx) : idx;

    if (bus.bit_valid) begin
      if (!bus.frame_start && state == PAR) begin
        // Even parity: data XOR parity must be 0.
        if (^{shreg, bus.bit_in}) begin
          perr_n = 1'b1;
        end else begin
          nibble_n = shreg;
          load_n   = 1'b1;
        end
        state_n   = IDLE;
        bit_cnt_n = '0;
      end else if (bus.frame_start || state == DATA) begin
        // Restart mid-frame silently drops the partial frame: the new bit
        // overwrites position 0 and the count restarts from 1.
        for (int i = 0; i < WIDTH; i++)
          if (i == pos) shreg_n[i] = bus.bit_in;
        if (idx == WIDTH - 1) begin
          if (PARITY_EN != 0) begin
            state_n   = PAR;
            bit_cnt_n = CW'(WIDTH);
          end else begin
            state_n   = IDLE;
            bit_cnt_n = '0;
            nibble_n  = shreg_n;
            load_n    = 1'b1;
          end
        end else begin
          state_n   = DATA;
          bit_cnt_n = CW'(idx + 1);
        end
      end
    end
  end

  assign bus.nibble_out = nibble_q;
  assign bus.load_en    = load_q;
  assign bus.parity_err = perr_q;
  assign bus.busy       = (state != IDLE);

endmodule
